// File: rtl/load_store_unit.sv
// Load/store unit: ready-handshake bus access with sized, sign/zero-extended loads.
// Optional bus timeout counter is built when LSU_TIMEOUT_EN is defined.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_read,
    input  logic                req_write,
    input  logic [2:0]          funct3,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [XLEN-1:0]     wdata,
    output logic [XLEN-1:0]     rdata,
    output logic                stall,
    output logic                misaligned,
    output logic                bus_error,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN-1:0]     bus_wdata,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [1:0]          bus_mode,
    input  logic [XLEN-1:0]     bus_rdata,
    input  logic                bus_ready
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              w_req;
    logic              w_size_ok;
    logic              w_aligned;
    logic              w_fault;
    logic              w_start;
    logic              w_done;
    logic              w_timeout;
    logic [OFF_W-1:0]  w_off;
    logic [BE_W-1:0]   w_mask;
    logic [XLEN-1:0]   w_wdata_rep;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_load;

    logic [XLEN-1:0]   r_rdata;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [XLEN-1:0]   r_bus_wdata;
    logic [BE_W-1:0]   r_bus_be;
    logic [1:0]        r_bus_mode;
    logic [OFF_W-1:0]  r_off;
    logic [2:0]        r_funct3;

    assign w_req = req_read | req_write;
    assign w_off = addr[OFF_W-1:0];

    // Stores never carry a sign bit; 64-bit sizes and LWU exist only on a 64-bit datapath.
    always_comb begin
        w_size_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_size_ok = 1'b1;
            3'b011:                 w_size_ok = (XLEN == 64);
            3'b100, 3'b101:         w_size_ok = ~req_write;
            3'b110:                 w_size_ok = (XLEN == 64) && !req_write;
            default:                w_size_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_aligned   = 1'b1;
        w_mask      = '1;
        w_wdata_rep = wdata;
        case (funct3[1:0])
            2'd0: begin
                w_mask      = BE_W'(1);
                w_wdata_rep = {BE_W{wdata[7:0]}};
            end
            2'd1: begin
                w_aligned   = ~addr[0];
                w_mask      = BE_W'(3);
                w_wdata_rep = {(XLEN/16){wdata[15:0]}};
            end
            2'd2: begin
                w_aligned   = (addr[1:0] == 2'b00);
                w_mask      = BE_W'(15);
                w_wdata_rep = {(XLEN/32){wdata[31:0]}};
            end
            default: begin
                w_aligned   = (addr[2:0] == 3'b000);
            end
        endcase
    end

    assign w_fault    = w_req & (~w_size_ok | ~w_aligned);
    assign w_start    = (r_state == S_IDLE) & w_req & ~w_fault;
    assign w_done     = (r_state == S_ACCESS) & (bus_ready | w_timeout);
    assign stall      = w_start | (r_state == S_ACCESS);
    assign misaligned = (r_state == S_IDLE) & w_fault;

    assign w_shifted = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load = '0;
        case (r_funct3)
            3'b000:  w_load = XLEN'($signed(w_shifted[7:0]));
            3'b001:  w_load = XLEN'($signed(w_shifted[15:0]));
            3'b010:  w_load = XLEN'($signed(w_shifted[31:0]));
            3'b011:  w_load = w_shifted;
            3'b100:  w_load = XLEN'(w_shifted[7:0]);
            3'b101:  w_load = XLEN'(w_shifted[15:0]);
            3'b110:  w_load = XLEN'(w_shifted[31:0]);
            default: w_load = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_ACCESS;
            S_ACCESS: if (bus_ready || w_timeout) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata     <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_bus_mode  <= 2'b00;
            r_off       <= '0;
            r_funct3    <= 3'b000;
        end else if (w_start) begin
            r_bus_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_bus_mode  <= req_write ? 2'b10 : 2'b01;
            r_bus_be    <= w_mask << w_off;
            r_bus_wdata <= w_wdata_rep;
            r_off       <= w_off;
            r_funct3    <= funct3;
        end else if (w_done) begin
            // A timed-out read returns zero just like a store does.
            r_rdata    <= (r_bus_mode == 2'b01 && bus_ready) ? w_load : '0;
            r_bus_mode <= 2'b00;
            r_bus_be   <= '0;
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_bus_error;

    assign w_timeout = ~bus_ready & (r_tmo_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt   <= 8'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_bus_error <= (r_state == S_ACCESS) & w_timeout;
            if (w_start) begin
                r_tmo_cnt <= 8'd0;
            end else if (r_state == S_ACCESS) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

    assign bus_error = r_bus_error;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = |8'(TIMEOUT);
    assign w_timeout        = 1'b0;
    assign bus_error        = 1'b0;
`endif

    assign rdata     = r_rdata;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;
    assign bus_mode  = r_bus_mode;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit and a 64-bit instance, directed and random
// accesses checked against a byte-lane reference model.
module tb_load_store_unit;

    localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] bus_rdata;
    logic        bus_ready;
    logic        rd32, wr32, rd64, wr64;

    logic [31:0] rdata32, bus_addr32, bus_wdata32, bus_addr64;
    logic [63:0] rdata64, bus_wdata64;
    logic [3:0]  bus_be32;
    logic [7:0]  bus_be64;
    logic [1:0]  bus_mode32, bus_mode64;
    logic        stall32, mis32, err32, stall64, mis64, err64;

    bit          sel64;
    logic [63:0] o_rdata, o_bus_wdata, o_bus_be, o_bus_addr;
    logic [1:0]  o_bus_mode;
    logic        o_stall, o_mis, o_err;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut32 (
        .clk(clk), .reset(reset), .req_read(rd32), .req_write(wr32),
        .funct3(funct3), .addr(addr), .wdata(wdata[31:0]), .rdata(rdata32),
        .stall(stall32), .misaligned(mis32), .bus_error(err32),
        .bus_addr(bus_addr32), .bus_wdata(bus_wdata32), .bus_be(bus_be32),
        .bus_mode(bus_mode32), .bus_rdata(bus_rdata[31:0]), .bus_ready(bus_ready)
    );

    load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO)) dut64 (
        .clk(clk), .reset(reset), .req_read(rd64), .req_write(wr64),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata64),
        .stall(stall64), .misaligned(mis64), .bus_error(err64),
        .bus_addr(bus_addr64), .bus_wdata(bus_wdata64), .bus_be(bus_be64),
        .bus_mode(bus_mode64), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always_comb begin
        o_rdata     = sel64 ? rdata64 : {32'b0, rdata32};
        o_bus_wdata = sel64 ? bus_wdata64 : {32'b0, bus_wdata32};
        o_bus_be    = sel64 ? {56'b0, bus_be64} : {60'b0, bus_be32};
        o_bus_addr  = sel64 ? {32'b0, bus_addr64} : {32'b0, bus_addr32};
        o_bus_mode  = sel64 ? bus_mode64 : bus_mode32;
        o_stall     = sel64 ? stall64 : stall32;
        o_mis       = sel64 ? mis64 : mis32;
        o_err       = sel64 ? err64 : err32;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit rd, input bit wr);
        if (sel64) begin
            rd64 = rd; wr64 = wr; rd32 = 1'b0; wr32 = 1'b0;
        end else begin
            rd32 = rd; wr32 = wr; rd64 = 1'b0; wr64 = 1'b0;
        end
    endtask

    // One access from request to the IDLE cycle after DONE; expectations come from byte lanes.
    task automatic do_access(input bit s64, input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [63:0] wd,
                             input logic [63:0] brd, input int waits);
        int xl, nb, off, acc, stall_cnt;
        bit legal, fault, tmo;
        logic [63:0] xmask, vmask, e_be, e_wd, e_rd, e_addr, val;
        xl    = s64 ? 64 : 32;
        nb    = 1 << f3[1:0];
        legal = (f3 != 3'b111) && !(wr && f3[2]) &&
                !((f3 == 3'b011 || f3 == 3'b110) && xl == 32);
        fault = !legal || (a % nb) != 0;
        off   = int'(a % (xl / 8));
        xmask = (xl == 64) ? '1 : 64'hFFFF_FFFF;
        e_addr = 64'(a) - 64'(off);
        e_be  = ((64'd1 << nb) - 64'd1) << off;
        e_wd  = '0;
        for (int j = 0; j < xl / 8; j++)
            e_wd |= ((wd >> (8 * (j % nb))) & 64'hFF) << (8 * j);
        vmask = (nb == 8) ? '1 : (64'd1 << (8 * nb)) - 64'd1;
        val   = (brd >> (8 * off)) & vmask;
        if (!f3[2] && val[8 * nb - 1]) val = val | ~vmask;
        tmo   = TMO_EN && (waits >= TO);
        e_rd  = (wr || tmo) ? 64'd0 : (val & xmask);
        acc   = tmo ? TO : waits + 1;

        sel64 = s64;
        funct3 = f3; addr = a; wdata = wd; bus_ready = 1'b0;
        drive_req(rd, wr);
        #1;
        if (fault) begin
            check("fault_misaligned", o_mis, 1'b1);
            check("fault_stall", o_stall, 1'b0);
            step();
            check("fault_no_bus", o_bus_mode, 2'b00);
            check("fault_still_idle", o_mis, 1'b1);
            drive_req(1'b0, 1'b0);
            return;
        end
        check("c0_misaligned", o_mis, 1'b0);
        stall_cnt = int'(o_stall);
        step();
        for (int k = 0; k < acc; k++) begin
            drive_req(1'($urandom), 1'($urandom));
            funct3 = 3'($urandom); addr = $urandom; wdata = {$urandom, $urandom};
            bus_ready = (k == waits);
            bus_rdata = (k == waits) ? brd : {$urandom, $urandom};
            #1;
            check("acc_addr", o_bus_addr, e_addr);
            check("acc_be", o_bus_be, e_be);
            check("acc_wdata", o_bus_wdata, e_wd);
            check("acc_mode", o_bus_mode, wr ? 2'b10 : 2'b01);
            stall_cnt += int'(o_stall);
            step();
        end
        bus_ready = 1'($urandom);
        #1;
        check("done_rdata", o_rdata, e_rd);
        check("done_stall", o_stall, 1'b0);
        check("done_error", o_err, tmo);
        check("done_mode", o_bus_mode, 2'b00);
        check("done_be", o_bus_be, 64'd0);
        check("stall_cycles", 64'(stall_cnt), 64'(acc + 1));
        drive_req(1'b0, 1'b0);
        step();
        check("idle_rdata_hold", o_rdata, e_rd);
        check("idle_error", o_err, 1'b0);
        check("idle_mode", o_bus_mode, 2'b00);
        bus_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          kind;
        reset = 1'b1; funct3 = 3'b000; addr = '0; wdata = '0; bus_rdata = '0;
        bus_ready = 1'b0; rd32 = 0; wr32 = 0; rd64 = 0; wr64 = 0; sel64 = 0;
        repeat (3) step();
        for (int s = 0; s < 2; s++) begin
            sel64 = bit'(s);
            #1;
            check("rst_rdata", o_rdata, 64'd0);
            check("rst_bus_addr", o_bus_addr, 64'd0);
            check("rst_bus_wdata", o_bus_wdata, 64'd0);
            check("rst_bus_be", o_bus_be, 64'd0);
            check("rst_bus_mode", o_bus_mode, 2'b00);
            check("rst_stall", o_stall, 1'b0);
            check("rst_mis", o_mis, 1'b0);
            check("rst_err", o_err, 1'b0);
        end
        reset = 1'b0;
        step();

        do_access(0, 1, 0, 3'b000, 32'h1003, 64'h0, 64'h80AB_CDEF, 0);
        check("lb_sign_ext", o_rdata, 64'hFFFF_FF80);
        do_access(0, 0, 1, 3'b001, 32'h2002, 64'h1234_5678, 64'h0, 1);
        check("sh_rdata_zero", o_rdata, 64'd0);
        do_access(0, 1, 0, 3'b010, 32'h2008, 64'h0, 64'hDEAD_BEEF, 3);
        check("lw_wait_rdata", o_rdata, 64'hDEAD_BEEF);
        do_access(0, 1, 0, 3'b010, 32'h3001, 64'h0, 64'h0, 0);
        do_access(0, 1, 1, 3'b100, 32'h3005, 64'h0000_00AA, 64'h0, 0);
        do_access(0, 1, 0, 3'b011, 32'h3008, 64'h0, 64'h0, 0);
        do_access(0, 1, 0, 3'b010, 32'h5000, 64'h0, 64'h1111_2222, 20);

        sel64 = 0;
        funct3 = 3'b010; addr = 32'h6004; bus_ready = 1'b0;
        drive_req(1'b1, 1'b0);
        step();
        check("mid_rst_access_mode", o_bus_mode, 2'b01);
        reset = 1'b1;
        drive_req(1'b0, 1'b0);
        step();
        reset = 1'b0;
        check("mid_rst_mode", o_bus_mode, 2'b00);
        check("mid_rst_be", o_bus_be, 64'd0);
        check("mid_rst_addr", o_bus_addr, 64'd0);
        check("mid_rst_wdata", o_bus_wdata, 64'd0);
        check("mid_rst_stall", o_stall, 1'b0);
        bus_ready = 1'b1;
        step();
        check("mid_rst_no_done_err", o_err, 1'b0);
        check("mid_rst_no_done_rdata", o_rdata, 64'd0);
        bus_ready = 1'b0;

        do_access(1, 1, 0, 3'b110, 32'h4004, 64'h0, 64'hFFFF_FFFF_0000_0000, 0);
        check("lwu64", o_rdata, 64'h0000_0000_FFFF_FFFF);
        do_access(1, 1, 0, 3'b011, 32'h4010, 64'h0, 64'h8877_6655_4433_2211, 2);
        do_access(1, 0, 1, 3'b010, 32'h4014, 64'hCAFE_F00D, 64'h0, 0);

        for (int i = 0; i < 60; i++) begin
            f3   = 3'($urandom);
            a    = $urandom;
            if ($urandom_range(0, 2) != 0) a[2:0] = 3'($urandom_range(0, 1) * 4);
            kind = $urandom_range(0, 2);
            do_access(1'($urandom), kind != 1, kind != 0, f3, a,
                      {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store unit between the core datapath and the data bus. It replaces the fixed one-wait-state load stall with a ready-handshake FSM. It also adds byte/halfword/word (and doubleword at XLEN=64) accesses, sign/zero extension, byte enables, misalignment detection and an optional bus timeout. The datapath holds its PC while `stall` is high and writes `rdata` back in the cycle `stall` drops.

## Interface
Reset is synchronous and active-high on `reset`. The block has a single clock, `clk`.

**Parameters**
- `XLEN`, 32: data width; legal values 32 or 64.
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 15: maximum ACCESS cycles without `bus_ready`. Legal range 1..255.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_read` in 1: load requested by the current instruction.
- `req_write` in 1: store requested by the current instruction.
- `funct3` in 3: RISC-V access size and signedness.
- `addr` in ADDR_W: effective address (ALU result).
- `wdata` in XLEN: store data (rs2).
- `rdata` out XLEN: extended load result.
- `stall` out 1: hold PC and instruction.
- `misaligned` out 1: access is misaligned or has an illegal size; the access is dropped.
- `bus_error` out 1: timeout pulse.
- `bus_addr` out ADDR_W: bus address, aligned down to XLEN/8 bytes.
- `bus_wdata` out XLEN: lane-replicated store data.
- `bus_be` out XLEN/8: byte enables.
- `bus_mode` out 2: 00 idle, 01 read, 10 write.
- `bus_rdata` in XLEN: bus read data.
- `bus_ready` in 1: slave completes the access.

## Operation
- **FSM states.** IDLE, ACCESS, DONE.
- **Request priority.**
  - `req = req_read | req_write`.
  - If both are high, the access is a write.
- **Size decode from `funct3`.**
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - 011 LD/SD and 110 LWU are legal only when XLEN=64.
  - Any other value is illegal.
  - Store sign bit `funct3[2]=1` is illegal.
- **Fault.** `fault` is combinational, evaluated in IDLE with `req` high. It is set when:
  - the size is illegal, or
  - the address is not aligned: half needs `addr[0]=0`, word needs `addr[1:0]=0`, double needs `addr[2:0]=0`.
  - When set, `misaligned=1` in that cycle, `stall=0`, no bus transaction occurs and the state stays IDLE. The datapath advances.
- **IDLE → ACCESS** when `req` is high and `fault` is low. On that edge the block registers:
  - `bus_addr`: `addr` with the low log2(XLEN/8) bits cleared.
  - `bus_mode`.
  - `bus_be`: the size mask shifted by the lane offset.
  - `bus_wdata`: the byte, half or word of `wdata` replicated across all lanes.
  - The offset and `funct3`, held for extension.
  - The timeout counter, cleared to 0.
- **ACCESS → DONE** on the first edge with `bus_ready=1`. On that edge:
  - Reads: `rdata` is loaded with `bus_rdata`, shifted right by offset×8, masked to the size, then sign-extended (LB/LH/LW at XLEN=64) or zero-extended.
  - Writes: `rdata` is loaded with 0.
- **ACCESS → DONE on timeout.** If the counter reaches TIMEOUT−1 with `bus_ready=0`, the FSM moves to DONE with `rdata=0` and `bus_error=1` during DONE.
- **DONE → IDLE** unconditionally.
  - `bus_mode=00` and `bus_be=0`.
- **Stall.**
  - `stall = (IDLE & req & ~fault) | ACCESS`.
  - `stall` is 0 in DONE, so the PC advances at the end of DONE.
- **Bus signal hold.** In ACCESS, all `bus_*` outputs are held stable regardless of changes on the request inputs.

## Timing
- **Reset values.** On reset, state=IDLE and every output and register is 0, including `rdata`, `bus_*`, `bus_error` and the counter.
  - `stall` and `misaligned` remain combinational, from IDLE, and are therefore 0 when `req=0`.
- **Minimum latency.** 3 cycles per access:
  - C0: IDLE, stall.
  - C1: ACCESS, bus driven, `bus_ready` sampled.
  - C2: DONE, `rdata` valid.
  - The next instruction's request is seen in C3 at the earliest.
- **Slower slaves.** Each cycle `bus_ready` stays low adds one cycle.
- **Maximum latency** with timeout enabled: TIMEOUT+2 cycles.
- **Unexpected `bus_ready`.** `bus_ready` high in IDLE or DONE is ignored.
- **Reset mid-ACCESS.** The transaction is abandoned. The next cycle is IDLE with `bus_mode=00`, and no DONE pulse occurs.
- **`rdata` hold.** `rdata` holds its value from DONE until the next completion.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8-bit timeout counter is instantiated.
  - Timeout behaves as described under Operation.
- `LSU_TIMEOUT_EN` undefined:
  - No counter is instantiated.
  - ACCESS waits indefinitely for `bus_ready`.
  - `bus_error` is tied to 0.

## Test plan
- **LB sign extension.** XLEN=32, LB at `addr`=0x1003, `bus_rdata`=0x80AB_CDEF, `bus_ready` high in C1.
  - C1: `bus_addr`=0x1000, `bus_be`=1000.
  - C2: `rdata`=0xFFFF_FF80, `stall` low.
- **SH lane select.** SH at `addr`=0x2002, `wdata`=0x1234_5678.
  - `bus_mode`=10, `bus_wdata`=0x5678_5678, `bus_be`=1100.
  - `rdata`=0 in DONE.
- **Wait states.** LW with `bus_ready` delayed 3 cycles.
  - `stall` high for 5 cycles.
  - `rdata`=`bus_rdata` in DONE.
- **Misaligned access.** LW at 0x3001.
  - `misaligned`=1 and `stall`=0 in the same cycle.
  - `bus_mode` stays 00.
- **Timeout.** With `LSU_TIMEOUT_EN`, TIMEOUT=4 and `bus_ready` held at 0.
  - DONE in the 6th cycle, `bus_error`=1, `rdata`=0.
  - Without the macro, `stall` stays high indefinitely.
- **Reset mid-ACCESS.** Assert `reset` in ACCESS.
  - Next cycle: IDLE, all `bus_*`=0.
- **XLEN=64 LWU.** LWU at 0x4004, `bus_rdata`=0xFFFF_FFFF_0000_0000.
  - `rdata`=0x0000_0000_FFFF_FFFF.
